// File: rtl/huffman_sched.sv
// Huffman code builder for 8 symbols that sequences an external 8-entry sort network.
// Optional macro HUFF_SORT_PIPE_EN inserts a wait state so a registered sorter gets two cycles per sort.
module huffman_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [4:0]  in_weight,
    output logic        busy,
    output logic [31:0] sort_char,
    output logic [39:0] sort_weight,
    input  logic [31:0] sort_result,
    output logic        out_valid,
    output logic [2:0]  out_sym,
    output logic [2:0]  out_len,
    output logic [6:0]  out_code,
    output logic        ovf
);
    localparam int NSYM  = 8;
    localparam int CW    = 7;
    localparam int NNODE = 15;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SORT,
`ifdef HUFF_SORT_PIPE_EN
        SORT_W,
`endif
        MERGE,
        OUT
    } state_t;

    state_t state, state_next;

    logic [4:0]    node_w    [NNODE];
    logic [7:0]    node_mask [NNODE];
    logic [2:0]    len       [NSYM];
    logic [CW-1:0] code      [NSYM];
    logic [3:0]    slot_id   [NSYM];
    logic [3:0]    n;
    logic [2:0]    k;
    logic [2:0]    cnt;

    logic [31:0] char_live, char_hold;
    logic [39:0] weight_live, weight_hold;
    logic        sorting, capture;

    logic [2:0] idx_a, idx_b;
    logic [3:0] id_a, id_b, new_id;
    logic [5:0] sum;
    logic [7:0] mask_a, mask_b;
    logic [4:0] in_w;

`ifdef HUFF_SORT_PIPE_EN
    assign sorting = (state == SORT) || (state == SORT_W);
    assign capture = (state == SORT_W);
`else
    assign sorting = (state == SORT);
    assign capture = (state == SORT);
`endif

    // Inactive slots present id 0 / weight 0 so they always land at the tail of the sort.
    always_comb begin
        char_live   = '0;
        weight_live = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (4'(i) < n) begin
                char_live[31-4*i -: 4]   = slot_id[i];
                weight_live[39-5*i -: 5] = node_w[slot_id[i]];
            end
        end
    end

    assign sort_char   = sorting ? char_live : char_hold;
    assign sort_weight = sorting ? weight_live : weight_hold;

    assign idx_a  = 3'(n - 4'd2);
    assign idx_b  = 3'(n - 4'd1);
    assign id_a   = slot_id[idx_a];
    assign id_b   = slot_id[idx_b];
    assign new_id = 4'd8 + {1'b0, k};
    assign sum    = {1'b0, node_w[id_a]} + {1'b0, node_w[id_b]};
    assign mask_a = node_mask[id_a];
    assign mask_b = node_mask[id_b];
    assign in_w   = (in_weight == 5'd0) ? 5'd1 : in_weight;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = LOAD;
            LOAD:    if (in_valid && cnt == 3'd7) state_next = SORT;
`ifdef HUFF_SORT_PIPE_EN
            SORT:    state_next = SORT_W;
            SORT_W:  state_next = MERGE;
`else
            SORT:    state_next = MERGE;
`endif
            MERGE:   state_next = (k == 3'd6) ? OUT : SORT;
            OUT:     if (cnt == 3'd7) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_sym     <= '0;
            out_len     <= '0;
            out_code    <= '0;
            ovf         <= 1'b0;
            char_hold   <= '0;
            weight_hold <= '0;
            n           <= '0;
            k           <= '0;
            cnt         <= '0;
            for (int i = 0; i < NNODE; i++) begin
                node_w[i]    <= '0;
                node_mask[i] <= '0;
            end
            for (int i = 0; i < NSYM; i++) begin
                len[i]     <= '0;
                code[i]    <= '0;
                slot_id[i] <= '0;
            end
        end else begin
            busy      <= (state != IDLE) || in_valid;
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_len   <= '0;
            out_code  <= '0;
            if (sorting) begin
                char_hold   <= char_live;
                weight_hold <= weight_live;
            end
            if (capture) begin
                for (int i = 0; i < NSYM; i++) slot_id[i] <= sort_result[31-4*i -: 4];
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        node_w[0]    <= in_w;
                        node_mask[0] <= 8'd1;
                        cnt          <= 3'd1;
                        for (int j = 0; j < NSYM; j++) begin
                            len[j]  <= '0;
                            code[j] <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        node_w[{1'b0, cnt}]    <= in_w;
                        node_mask[{1'b0, cnt}] <= 8'd1 << cnt;
                        cnt                    <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            for (int i = 0; i < NSYM; i++) slot_id[i] <= 4'(i);
                            n <= 4'd8;
                            k <= 3'd0;
                        end
                    end
                end
                MERGE: begin
                    node_w[new_id]    <= sum[4:0];
                    node_mask[new_id] <= mask_a | mask_b;
                    ovf               <= ovf | sum[5];
                    // Codes start cleared, so the "0" branch only needs to grow the length.
                    for (int j = 0; j < NSYM; j++) begin
                        if (mask_a[j] || mask_b[j]) len[j] <= len[j] + 3'd1;
                        if (mask_b[j]) code[j] <= code[j] | (7'd1 << len[j]);
                    end
                    slot_id[idx_a] <= new_id;
                    n              <= n - 4'd1;
                    k              <= k + 3'd1;
                    if (k == 3'd6) cnt <= 3'd0;
                end
                OUT: begin
                    out_valid <= 1'b1;
                    out_sym   <= cnt;
                    out_len   <= len[cnt];
                    out_code  <= code[cnt];
                    cnt       <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_huffman_sched.sv
// Directed bench for huffman_sched with a behavioural model of the shared sort network.
module tb_huffman_sched;
`ifdef HUFF_SORT_PIPE_EN
    localparam int ITER = 3;
`else
    localparam int ITER = 2;
`endif
    localparam int LAT = 7 * ITER + 1;

    logic        clk, rst, in_valid;
    logic [4:0]  in_weight;
    logic        busy, out_valid, ovf;
    logic [31:0] sort_char, sort_result;
    logic [39:0] sort_weight;
    logic [2:0]  out_sym, out_len;
    logic [6:0]  out_code;

    int checks = 0;
    int errors = 0;

    logic [4:0] wts      [8];
    logic [2:0] exp_len  [8];
    logic [6:0] exp_code [8];
    logic [2:0] res_len  [8];
    logic [6:0] res_code [8];
    int  lat, got_n;
    bit  order_ok, ovf_pre, ovf_post, busy_last;

    huffman_sched dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_weight(in_weight),
        .busy(busy), .sort_char(sort_char), .sort_weight(sort_weight),
        .sort_result(sort_result), .out_valid(out_valid), .out_sym(out_sym),
        .out_len(out_len), .out_code(out_code), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sorter: descending weight, equal weights put the larger id first.
    function automatic logic [31:0] sort_net(input logic [31:0] c, input logic [39:0] w);
        logic [8:0]  key [8];
        logic [8:0]  t;
        logic [31:0] r;
        for (int i = 0; i < 8; i++) key[i] = {w[39-5*i -: 5], c[31-4*i -: 4]};
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7 - i; j++)
                if (key[j] < key[j+1]) begin
                    t = key[j]; key[j] = key[j+1]; key[j+1] = t;
                end
        r = '0;
        for (int i = 0; i < 8; i++) r[31-4*i -: 4] = key[i][3:0];
        return r;
    endfunction

    always_comb sort_result = sort_net(sort_char, sort_weight);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_sym"}, 32'(out_sym), 0);
        check({tag, "_out_len"}, 32'(out_len), 0);
        check({tag, "_out_code"}, 32'(out_code), 0);
        check({tag, "_ovf"}, 32'(ovf), 0);
        check({tag, "_sort_char"}, sort_char, 0);
        check({tag, "_sort_weight_hi"}, {24'd0, sort_weight[39:32]}, 0);
        check({tag, "_sort_weight_lo"}, sort_weight[31:0], 0);
    endtask

    task automatic load(input bit gap);
        for (int s = 0; s < 8; s++) begin
            if (gap && s > 0) begin
                in_valid  = 1'b0;
                in_weight = 5'($urandom_range(0, 31));
                @(posedge clk); #1;
            end
            in_valid  = 1'b1;
            in_weight = wts[s];
            @(posedge clk); #1;
            if (s == 0) check("busy_rise", 32'(busy), 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input bit pulse);
        int cyc = 0;
        got_n    = 0;
        lat      = -1;
        order_ok = 1'b1;
        while (got_n < 8 && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == LAT - 2) ovf_pre = ovf;
            if (cyc == LAT - 1) ovf_post = ovf;
            if (out_valid) begin
                if (got_n == 0) lat = cyc;
                if (out_sym != 3'(got_n)) order_ok = 1'b0;
                res_len[out_sym]  = out_len;
                res_code[out_sym] = out_code;
                busy_last = busy;
                got_n++;
            end
            if (pulse && got_n < 6) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_weight = 5'($urandom_range(0, 31));
            end else begin
                in_valid = 1'b0;
            end
        end
        check("out_count", 32'(got_n), 8);
        check("out_order", 32'(order_ok), 1);
        check("busy_last_out", 32'(busy_last), 1);
        @(posedge clk); #1;
        check("busy_after", 32'(busy), 0);
        check("out_valid_after", 32'(out_valid), 0);
    endtask

    task automatic check_codes(input string tag);
        for (int s = 0; s < 8; s++) begin
            check($sformatf("%s_len%0d", tag, s), 32'(res_len[s]), 32'(exp_len[s]));
            check($sformatf("%s_code%0d", tag, s), 32'(res_code[s]), 32'(exp_code[s]));
        end
    endtask

    task automatic expect_flat;
        for (int s = 0; s < 8; s++) begin
            exp_len[s]  = 3'd3;
            exp_code[s] = 7'(7 - s);
        end
    endtask

    task automatic expect_skew;
        exp_len[0] = 3'd1; exp_code[0] = 7'b0;
        exp_len[1] = 3'd4; exp_code[1] = 7'b1101;
        exp_len[2] = 3'd4; exp_code[2] = 7'b1100;
        exp_len[3] = 3'd4; exp_code[3] = 7'b1011;
        exp_len[4] = 3'd4; exp_code[4] = 7'b1010;
        exp_len[5] = 3'd4; exp_code[5] = 7'b1001;
        exp_len[6] = 3'd4; exp_code[6] = 7'b1000;
        exp_len[7] = 3'd3; exp_code[7] = 7'b111;
    endtask

    initial begin
        int kraft, viol;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_weight = '0;
        ovf_pre   = 1'b0;
        ovf_post  = 1'b0;
        busy_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset");

        // All weights equal: balanced tree, lower id gets the 1 branch.
        for (int s = 0; s < 8; s++) wts[s] = 5'd2;
        load(1'b0);
        collect(1'b0);
        expect_flat();
        check_codes("flat");
        check("flat_latency", 32'(lat), 32'(LAT));
        check("flat_ovf", 32'(ovf), 0);

        // One heavy symbol.
        wts[0] = 5'd16;
        for (int s = 1; s < 8; s++) wts[s] = 5'd1;
        load(1'b0);
        collect(1'b0);
        expect_skew();
        check_codes("skew");
        check("skew_ovf", 32'(ovf), 0);

        // Zero weight is promoted to 1.
        wts[0] = 5'd0;
        for (int s = 1; s < 8; s++) wts[s] = 5'd2;
        load(1'b0);
        collect(1'b0);
        kraft = 0;
        viol  = 0;
        for (int i = 0; i < 8; i++) begin
            kraft += 1 << (7 - int'(res_len[i]));
            for (int j = 0; j < 8; j++)
                if (i != j && res_len[i] != 0 && res_len[i] <= res_len[j] &&
                    (res_code[j] >> (res_len[j] - res_len[i])) == res_code[i]) viol++;
        end
        check("zero_kraft", 32'(kraft), 128);
        check("zero_prefix_viol", 32'(viol), 0);
        check("zero_len0_3or4", 32'(res_len[0] == 3'd3 || res_len[0] == 3'd4), 1);
        check("zero_ovf", 32'(ovf), 0);

        // Sum 40: only the final merge carries out.
        for (int s = 0; s < 8; s++) wts[s] = 5'd5;
        load(1'b0);
        collect(1'b0);
        expect_flat();
        check_codes("big");
        check("big_ovf_before_last", 32'(ovf_pre), 0);
        check("big_ovf_at_last", 32'(ovf_post), 1);
        check("big_ovf_end", 32'(ovf), 1);

        // Gapped load, stray in_valid while building; ovf stays sticky.
        for (int s = 0; s < 8; s++) wts[s] = 5'd2;
        load(1'b1);
        collect(1'b1);
        expect_flat();
        check_codes("gap");
        check("gap_latency", 32'(lat), 32'(LAT));
        check("gap_ovf_sticky", 32'(ovf), 1);

        // Reset during the fourth merge.
        load(1'b0);
        repeat (4 * ITER - 1) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("midrst");
        rst = 1'b0;
        load(1'b0);
        collect(1'b0);
        expect_flat();
        check_codes("after_rst");
        check("after_rst_latency", 32'(lat), 32'(LAT));
        check("after_rst_ovf", 32'(ovf), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/huffman_sched.md
Name: huffman_sched

Overview:
- Sequences the shared 8-entry combinational sort network (IP_WIDTH=8, 4-bit char, 5-bit weight) to build a Huffman code for 8 symbols.
- Loads symbol weights serially, then runs 7 sort/merge iterations. Each iteration drives the sorter with the current node list and merges the two lightest nodes.
- Streams per-symbol code length and code word.
- Sits between the lab6 input FSM and the output serializer. The sorter is instantiated by the parent and wired to the sort_* ports.

Parameters:
- NSYM, 8, number of leaf symbols; fixed to 8 (the sorter width).
- CW, 7, code word / max length width (NSYM-1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  one symbol weight per cycle, symbols 0..7 in order
- in_weight  in  5  leaf weight; 0 is forced to 1 internally
- busy  out  1  high from first accepted in_valid until the last out_valid
- sort_char  out  32  node IDs to the sorter, slot0 in bits [31:28]
- sort_weight  out  40  node weights to the sorter, slot0 in bits [39:35]
- sort_result  in  32  sorter output: descending weight, ties larger ID first, slot0 in [31:28]
- out_valid  out  1  code output strobe, 8 consecutive cycles
- out_sym  out  3  symbol index 0..7
- out_len  out  3  code length 1..7
- out_code  out  7  code word right-aligned; bit[out_len-1] is the root-level bit; unused upper bits are 0
- ovf  out  1  sticky; set if any merged weight exceeds 31

Behaviour:
- Reset (sync, rst=1 at posedge) applies in any state, including mid-operation:
  - FSM returns to IDLE.
  - busy=0, out_valid=0, out_sym=0, out_len=0, out_code=0, ovf=0.
  - sort_char=0, sort_weight=0.
  - All tables cleared.
- Tables:
  - node_w[0..14] (5b) and node_mask[0..14] (8b); IDs 0-7 are leaves, 8-14 are internal.
  - Per-leaf len[0..7] and code[0..7].
  - Slot list slot_id[0..7] plus an active count n.
- States: IDLE, LOAD, SORT, MERGE, OUT.
- IDLE:
  - in_valid=1 stores symbol 0 (node_w[0]=max(w,1), node_mask[0]=1<<0) and moves to LOAD with cnt=1.
  - busy rises the following cycle.
- LOAD:
  - Each in_valid=1 cycle stores symbol cnt; cycles with in_valid low are waited out.
  - After symbol 7: slot_id[i]=i, n=8, k=0, go to SORT.
- SORT (1 cycle):
  - Active slot i<n drives sort_char=slot_id[i] and sort_weight=node_w[slot_id[i]].
  - Inactive slot drives char 0, weight 0; it always sorts to the tail because active weights are >=1.
  - sort_result is registered into slot_id at the end of the cycle; go to MERGE.
- MERGE (1 cycle), with a=slot_id[n-2] and b=slot_id[n-1]:
  - New node 8+k gets node_w = node_w[a]+node_w[b], truncated to 5 bits; ovf set if the carry is 1.
  - node_mask[8+k] = node_mask[a] | node_mask[b].
  - Leaves in mask[a]: code[len]=0, then len++. Leaves in mask[b]: code[len]=1, then len++.
  - slot_id[n-2]=8+k, n--, k++.
  - If k reaches 7 go to OUT with cnt=0, else go to SORT.
- Sort drive outside SORT: sort_char/sort_weight keep their last values; the sorter output is ignored.
- OUT:
  - out_valid=1 for cnt=0..7, presenting out_sym=cnt, out_len=len[cnt], out_code=code[cnt] (registered).
  - After cnt=7: return to IDLE; busy and out_valid drop the next cycle.
- in_valid during SORT/MERGE/OUT is ignored (no error).
- Latency: last LOAD input -> first out_valid = 15 cycles (7 x 2 + 1).
- Tie rule: the lower-ID node of an equal-weight tail pair receives bit 1, as dictated by the sorter ordering.

Optional Feature:
- HUFF_SORT_PIPE_EN defined:
  - Adds a wait state SORT_W between SORT and MERGE.
  - Sorter inputs are held for 2 cycles and sort_result is captured on the second cycle, for a registered/retimed sorter.
  - Latency per iteration is 3 cycles; last input -> first out_valid = 22 cycles.
- Undefined: 2-cycle iteration as above.

Test Plan:
- Weights all 2 -> every out_len=3. Symbol codes: 0->111, 1->110, 2->101, 3->100, 4->011, 5->010, 6->001, 7->000. ovf=0. First out_valid exactly 15 cycles after the last in_valid.
- Weights {16,1,1,1,1,1,1,1} -> len {1,4,4,4,4,4,4,3}. Codes: sym0=0, sym1=1101, sym2=1100, sym3=1011, sym4=1010, sym5=1001, sym6=1000, sym7=111.
- Weights {0,...} with sym0=0 and the rest 2 -> sym0 treated as weight 1; outputs are a valid prefix code with sym0 at len 3 or 4 and Kraft sum exactly 1 (bench checks the Kraft sum).
- Weights all 5 (sum 40) -> ovf=1 at the merge where the sum first exceeds 31; the 8 outputs are still streamed; ovf clears only on rst.
- in_valid gapped (high every other cycle) during LOAD -> same result as contiguous input. in_valid pulsed during MERGE/OUT -> no effect.
- rst asserted during MERGE of iteration 3 -> next cycle all outputs 0, busy=0. A new 8-symbol load then produces the correct codes from the first test.
